// File: rtl/parity_accum_if.sv
// Word-stream bundle between a frame source (master) and the parity accumulator (slave).
interface parity_accum_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_WORDS = 16
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             exp_par;
  logic             word_par;
  logic             word_vld;
  logic             frame_par;
  logic             frame_vld;
  logic             frame_err;
  logic [CW-1:0]    word_cnt;
  logic             overflow;

  modport master (
    output in_valid, in_data, in_last, exp_par,
    input  word_par, word_vld, frame_par, frame_vld, frame_err, word_cnt, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, exp_par,
    output word_par, word_vld, frame_par, frame_vld, frame_err, word_cnt, overflow
  );
endinterface

// File: rtl/parity_accum.sv
// Per-word and per-frame parity accumulator with frame-length check and
// zero-bubble back-to-back frame support.
module parity_accum #(
  parameter int WIDTH     = 4,
  parameter int MAX_WORDS = 16,
  parameter int ODD       = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  parity_accum_if.slave bus
);
  localparam int   CW     = $clog2(MAX_WORDS + 1);
  localparam logic ODDBIT = (ODD != 0);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          wpar_q, wpar_d;
  logic          wvld_q, wvld_d;
  logic          fpar_q, fpar_d;
  logic          fvld_q, fvld_d;
  logic          ferr_q, ferr_d;

  logic          wordXor;
  logic          firstWord;
  logic          accNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wpar_q  <= 1'b0;
      wvld_q  <= 1'b0;
      fpar_q  <= 1'b0;
      fvld_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      wpar_q  <= wpar_d;
      wvld_q  <= wvld_d;
      fpar_q  <= fpar_d;
      fvld_q  <= fvld_d;
      ferr_q  <= ferr_d;
    end
  end

  // DONE behaves like IDLE for the next word, so a word arriving there opens a new frame.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    wpar_d    = wpar_q;
    wvld_d    = 1'b0;
    fpar_d    = fpar_q;
    fvld_d    = 1'b0;
    ferr_d    = ferr_q;
    wordXor   = ^bus.in_data;
    firstWord = (state_q != ACCUM);
    accNext   = firstWord ? wordXor : (acc_q ^ wordXor);

    if (clr) begin
      state_d = IDLE;
      acc_d   = 1'b0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      wpar_d  = 1'b0;
      fpar_d  = 1'b0;
      ferr_d  = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.in_valid && bus.in_last) state_d = DONE;
        end
        default: begin
          if (bus.in_valid) state_d = bus.in_last ? DONE : ACCUM;
          else              state_d = IDLE;
        end
      endcase

      if (bus.in_valid) begin
        acc_d  = accNext;
        wpar_d = wordXor ^ ODDBIT;
        wvld_d = 1'b1;
        if (firstWord)                       cnt_d = CW'(1);
        else if (cnt_q != CW'(MAX_WORDS))    cnt_d = cnt_q + CW'(1);
        // Overflow is judged against the running frame only, never a finished one.
        if (!firstWord && cnt_q == CW'(MAX_WORDS) && !bus.in_last) ovf_d = 1'b1;
        if (bus.in_last) begin
          fpar_d = accNext ^ ODDBIT;
          ferr_d = accNext ^ ODDBIT ^ bus.exp_par;
          fvld_d = 1'b1;
        end
      end else if (state_q != ACCUM) begin
        cnt_d = '0;
      end
    end
  end

  assign bus.word_par  = wpar_q;
  assign bus.word_vld  = wvld_q;
  assign bus.frame_par = fpar_q;
  assign bus.frame_vld = fvld_q;
  assign bus.frame_err = ferr_q;
  assign bus.word_cnt  = cnt_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: doc/parity_accum.md
PARITY_ACCUM -- requirements
Module: parity_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data word width, legal range 2..32.
REQ-002 SHALL have parameter MAX_WORDS, default 16: maximum words per frame, legal range 2..256.
REQ-003 SHALL have parameter ODD, default 0: 0 selects even parity and 1 selects odd parity (XOR result inverted).
REQ-004 SHALL have local CW = $clog2(MAX_WORDS+1).
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-007 clr  in  1  synchronous clear.
REQ-008 in_valid  in  1  in_data/in_last/exp_par qualify; a word SHALL be accepted every cycle in_valid=1 (no backpressure).
REQ-009 in_data  in  WIDTH  data word.
REQ-010 in_last  in  1  marks final word of frame.
REQ-011 exp_par  in  1  expected frame parity, sampled only with in_last.
REQ-012 word_par  out  1  registered per-word parity.
REQ-013 word_vld  out  1  one-cycle pulse qualifying word_par.
REQ-014 frame_par  out  1  registered frame parity.
REQ-015 frame_vld  out  1  one-cycle pulse qualifying frame_par/frame_err.
REQ-016 frame_err  out  1  frame_par != sampled exp_par.
REQ-017 word_cnt  out  CW  words accepted in current frame.
REQ-018 overflow  out  1  sticky frame-length violation flag.

Function
REQ-019 SHALL implement states IDLE, ACCUM, DONE.
REQ-020 IDLE: in_valid & in_last -> DONE; in_valid & !in_last -> ACCUM; else stay.
REQ-021 ACCUM: in_valid & in_last -> DONE; else stay.
REQ-022 DONE SHALL last exactly one cycle; the exit transition SHALL follow the IDLE rules, so a word accepted in DONE starts the next frame (back-to-back frames, zero bubble).
REQ-023 Accumulator SHALL load ^in_data on a first word (accepted in IDLE or DONE) and XOR in ^in_data on later words (accepted in ACCUM).
REQ-024 On any accepted word, word_par SHALL be ^in_data ^ ODD and word_vld SHALL be 1, both one cycle after acceptance.
REQ-025 On in_last acceptance, frame_par SHALL be (accumulator value including the last word) ^ ODD; frame_err SHALL be frame_par ^ exp_par; frame_vld SHALL be 1, all one cycle after acceptance (in DONE).
REQ-026 frame_par and frame_err SHALL hold until the next frame_vld.
REQ-027 word_cnt SHALL be 1 after the first word, increment per accepted word, saturate at MAX_WORDS, and read 0 in IDLE.
REQ-028 A word accepted while word_cnt==MAX_WORDS and in_last=0 SHALL set overflow=1; the accumulator SHALL keep absorbing words.
REQ-029 overflow SHALL stay set until clr or reset.
REQ-030 clr=1 SHALL take priority over in_valid the same cycle: the word is dropped, state goes to IDLE, and the accumulator, word_cnt, overflow, all outputs and the pulse outputs go to 0.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and all outputs and internal registers to 0, regardless of clk, including mid-frame; the partial frame SHALL be discarded with no frame_vld.
REQ-032 After rst_n rises, the first in_valid word SHALL be treated as a first word.

Verification (WIDTH=4, MAX_WORDS=16, ODD=0 unless stated)
REQ-033 Single-word frame in_data=4'b0111, in_last=1, exp_par=1 -> next cycle: word_par=1, frame_vld=1, frame_par=1, frame_err=0, word_cnt=1.
REQ-034 16-word frame in_data=0..15 with in_last on 15, exp_par=1 -> frame_par=0, frame_err=1, word_cnt=16, overflow=0.
REQ-035 Back-to-back: frame A ends at cycle n, frame B's first word 4'b0001 at n+1 -> frame_vld=1 at n+1, B's accumulator=1, no lost word.
REQ-036 17 words without in_last -> overflow=1 one cycle after the 17th word, word_cnt=16; clr -> overflow=0, word_cnt=0.
REQ-037 rst_n low between clk edges mid-frame (3 words in) -> outputs 0 immediately; next frame 4'b1000 alone gives frame_par=1.
REQ-038 ODD=1, single word 4'b0000 with in_last -> word_par=1, frame_par=1.
